// File: rtl/ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_tx
//  Description : Fixed-format asynchronous serial transmitter. It sends one
//                start bit (0), eight data bits LSB first, an optional
//                even-parity bit and one stop bit (1). Each bit is held for
//                CLKS_PER_BIT clock cycles.
//                Optional feature macro: ASCII_TX_PARITY_EN. When it is
//                defined, an even-parity bit is sent after data[7].
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_tx #(
    parameter int CLKS_PER_BIT = 16        // legal range 2..65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ascii,
    output logic       busy,
    output logic       done
);

    // The tick counter only has to reach CLKS_PER_BIT-1.
    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Last tick of a bit period. The bit boundary is taken on this tick.
    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(CLKS_PER_BIT - 1);

    // The done flop is set one tick before the final stop cycle. Because
    // done is registered, the pulse then appears in exactly that final cycle.
    localparam logic [TICK_W-1:0] c_tick_done = TICK_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef ASCII_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_ascii;
    logic               r_busy;
    logic               r_done;
`ifdef ASCII_TX_PARITY_EN
    logic               r_parity;
`endif

    // All outputs come directly from flops, so the line cannot glitch.
    assign ascii = r_ascii;
    assign busy  = r_busy;
    assign done  = r_done;

    // Frame sequencer. A single process owns the state, the counters, the
    // shift register and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ascii   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ASCII_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ascii <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_tick  <= '0;
                    // This state is only reached when busy is already low.
                    // A load here is therefore always a legal request.
                    if (load) begin
                        r_shift   <= data;
                        r_bit_cnt <= '0;
                        r_ascii   <= 1'b0;      // start bit appears next cycle
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
`ifdef ASCII_TX_PARITY_EN
                        r_parity  <= ^data;     // even parity over the captured byte
`endif
                    end
                end

                ST_START: begin
                    if (r_tick == c_tick_last) begin
                        r_tick    <= '0;
                        r_bit_cnt <= '0;
                        r_ascii   <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_tick == c_tick_last) begin
                        r_tick <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            // Leave after bit 7. The counter is never
                            // allowed to wrap into a ninth data bit.
`ifdef ASCII_TX_PARITY_EN
                            r_ascii <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_ascii <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            // Bit 0 of r_shift is the bit now on the line.
                            // Bit 1 is the next bit to send.
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_ascii   <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

`ifdef ASCII_TX_PARITY_EN
                ST_PARITY: begin
                    if (r_tick == c_tick_last) begin
                        r_tick  <= '0;
                        r_ascii <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (r_tick == c_tick_last) begin
                        // The final stop cycle has just ended. Drop busy and
                        // done together, then return to the idle line level.
                        r_tick  <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ascii <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                        if (r_tick == c_tick_done) begin
                            r_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_tick  <= '0;
                    r_ascii <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_tx
//  Description : Self-checking bench for ascii_tx. It drives two instances,
//                one with CLKS_PER_BIT=4 and one with CLKS_PER_BIT=2.
//                Expected serial bits are queued when a byte is loaded and
//                are popped as the line is observed. Define
//                ASCII_TX_PARITY_EN to expect the parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_tx;

`ifdef ASCII_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load4;
    logic       load2;
    logic       sel;            // 0: drive and observe the /4 instance, 1: the /2 instance
    logic [7:0] data;
    logic       ascii4, busy4, done4;
    logic       ascii2, busy2, done2;
    logic       cur_ascii, cur_busy, cur_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    ascii_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .load  (load4),
        .data  (data),
        .ascii (ascii4),
        .busy  (busy4),
        .done  (done4)
    );

    ascii_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .load  (load2),
        .data  (data),
        .ascii (ascii2),
        .busy  (busy2),
        .done  (done2)
    );

    assign cur_ascii = sel ? ascii2 : ascii4;
    assign cur_busy  = sel ? busy2  : busy4;
    assign cur_done  = sel ? done2  : done4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle. Sampling and driving happen 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic v);
        if (sel) load2 = v;
        else     load4 = v;
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef ASCII_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Load a byte this cycle, then change data afterwards. The change must
    // have no effect on the frame already accepted.
    task automatic send(input logic [7:0] d);
        data = d;
        drive_load(1'b1);
        push_frame(d);
        tick();
        drive_load(1'b0);
        data = ~d;
    endtask

    // Observe one frame, starting at cycle 1 after acceptance. If inj_cycle
    // is non-zero, a spurious load with inj_data is applied in that cycle.
    task automatic check_frame(input int inj_cycle, input logic [7:0] inj_data);
        int   cpb;
        int   nbits;
        int   cyc;
        int   busy_cnt;
        logic b;
        cpb      = sel ? 2 : 4;
        nbits    = exp_q.size();
        cyc      = 1;
        busy_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            b = exp_q.pop_front();
            for (int k = 0; k < cpb; k++) begin
                check($sformatf("ascii cpb%0d c%0d", cpb, cyc), 32'(cur_ascii), 32'(b));
                check($sformatf("busy cpb%0d c%0d", cpb, cyc), 32'(cur_busy), 32'd1);
                check($sformatf("done cpb%0d c%0d", cpb, cyc), 32'(cur_done),
                      32'((i == nbits - 1) && (k == cpb - 1)));
                if (cur_busy) busy_cnt++;
                if (cyc == inj_cycle) begin
                    data = inj_data;
                    drive_load(1'b1);
                end
                tick();
                if (cyc == inj_cycle) drive_load(1'b0);
                cyc++;
            end
        end
        check($sformatf("busy_len cpb%0d", cpb), 32'(busy_cnt), 32'(nbits * cpb));
        check($sformatf("idle ascii cpb%0d", cpb), 32'(cur_ascii), 32'd1);
        check($sformatf("idle busy cpb%0d", cpb), 32'(cur_busy), 32'd0);
        check($sformatf("idle done cpb%0d", cpb), 32'(cur_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        load4 = 1'b0;
        load2 = 1'b0;
        sel   = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        check("rst ascii4", 32'(ascii4), 32'd1);
        check("rst busy4",  32'(busy4),  32'd0);
        check("rst done4",  32'(done4),  32'd0);
        check("rst ascii2", 32'(ascii2), 32'd1);
        check("rst busy2",  32'(busy2),  32'd0);
        check("rst done2",  32'(done2),  32'd0);
        reset = 1'b0;
        tick();

        // Basic frame: 0x41.
        send(8'h41);
        check_frame(0, 8'h00);

        // Back-to-back frame. A load during the frame at cycle 10 is ignored.
        send(8'h55);
        check_frame(10, 8'hFF);

        // A load in the done cycle is ignored, and the line stays idle.
        send(8'hC3);
        check_frame(NBITS * 4, 8'h0F);
        tick();
        check("done-load ignored busy", 32'(busy4), 32'd0);
        check("done-load ignored ascii", 32'(ascii4), 32'd1);

        // Reset in the middle of a frame at cycle 20.
        send(8'hA5);
        for (int c = 1; c < 20; c++) tick();
        reset = 1'b1;
        tick();
        check("abort ascii", 32'(ascii4), 32'd1);
        check("abort busy",  32'(busy4),  32'd0);
        check("abort done",  32'(done4),  32'd0);
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 45; c++) begin
            check($sformatf("post-abort done c%0d", c), 32'(done4), 32'd0);
            check($sformatf("post-abort ascii c%0d", c), 32'(ascii4), 32'd1);
            tick();
        end
        send(8'h3C);
        check_frame(0, 8'h00);

        // Reset takes priority over load in the same cycle.
        reset = 1'b1;
        data  = 8'h99;
        load4 = 1'b1;
        tick();
        reset = 1'b0;
        load4 = 1'b0;
        check("rst+load busy",  32'(busy4),  32'd0);
        check("rst+load ascii", 32'(ascii4), 32'd1);
        tick();
        check("rst+load busy2", 32'(busy4),  32'd0);
        check("rst+load ascii2", 32'(ascii4), 32'd1);

        // Parity patterns. These frames are 10 bits when parity is disabled.
        send(8'h07);
        check_frame(0, 8'h00);
        send(8'h03);
        check_frame(0, 8'h00);

        // Minimum bit period.
        sel = 1'b1;
        tick();
        send(8'h00);
        check_frame(0, 8'h00);
        send(8'hFF);
        check_frame(3, 8'h12);
        send(8'h41);
        check_frame(0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascii_tx.md
ASCII_TX -- requirements
Module: ascii_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 SHALL have port: load  input  1  request to transmit data; accepted only when busy=0.
REQ-005 SHALL have port: data  input  8  byte to send; sampled only in the cycle load is accepted.
REQ-006 SHALL have port: ascii  output  1  serial line, registered; idle level 1.
REQ-007 SHALL have port: busy  output  1  registered; 1 from the cycle after acceptance through the last stop-bit cycle.
REQ-008 SHALL have port: done  output  1  registered one-cycle pulse in the last cycle of the stop bit.

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-010 SHALL accept load when state=IDLE and busy=0, capturing data into an internal 8-bit shift register.
REQ-011 SHALL drive ascii=0 (start bit) from the cycle after acceptance; latency load->start edge = 1 cycle.
REQ-012 SHALL hold every bit on ascii for exactly CLKS_PER_BIT cycles, timed by an internal tick counter reset at each bit boundary.
REQ-013 SHALL send, in order: start 0, data[0]..data[7] (LSB first, right-shift), optional parity, stop 1.
REQ-014 SHALL use a 3-bit bit counter in DATA; leave DATA after bit index 7 completes, with no wrap into a ninth data bit.
REQ-015 SHALL assert done for exactly the final cycle of STOP and deassert busy in the next cycle, returning to IDLE with ascii=1.
REQ-016 SHALL ignore load while busy=1, including the done cycle; the in-flight frame and captured byte remain unchanged.
REQ-017 SHALL support back-to-back frames: load accepted in the first busy=0 cycle gives a minimum gap of one idle cycle (ascii=1) between frames.
REQ-018 SHALL total 10*CLKS_PER_BIT busy cycles per frame without parity and 11*CLKS_PER_BIT with it.
REQ-019 SHALL keep ascii glitch-free: it changes only at bit boundaries, from a flop.
REQ-020 SHALL ignore changes on data outside the acceptance cycle.

Reset
REQ-021 SHALL, on reset=1, set the state to IDLE, ascii=1, busy=0, done=0, and clear the tick counter, bit counter and shift register, all by the next posedge.
REQ-022 SHALL abort any frame in progress when reset occurs mid-frame, with no partial stop bit or done pulse; ascii=1 from the cycle after reset.
REQ-023 SHALL give reset priority over load; a load asserted in the same cycle as reset is discarded.

Configuration
REQ-024 SHALL, with ASCII_TX_PARITY_EN defined, compile in the PARITY state and send one even-parity bit (XOR of data[7:0]) between data[7] and the stop bit; frame = 11 bits.
REQ-025 SHALL, without ASCII_TX_PARITY_EN, contain no parity logic; DATA goes directly to STOP; frame = 10 bits.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, load with data=0x41 at cycle 0 -> ascii is 0 for cycles 1-4; then 1,0,0,0,0,0,1,0 for 4 cycles each; then 1 for cycles 37-40; done=1 only at 40; busy=0 at 41.
REQ-027 SHALL cover: load with data=0x55 at cycle 0, load with data=0xFF at cycle 10 -> second load ignored; serial data bits are 1,0,1,0,1,0,1,0.
REQ-028 SHALL cover: load asserted again in the cycle after done -> new start bit exactly two cycles after done; one idle cycle at ascii=1.
REQ-029 SHALL cover: reset asserted at cycle 20 of a frame -> next cycle ascii=1, busy=0, done=0; no done pulse follows; a new load then produces a clean full frame.
REQ-030 SHALL cover: with ASCII_TX_PARITY_EN, data=0x07 -> parity bit 1; data=0x03 -> parity bit 0; busy lasts 11*CLKS_PER_BIT cycles.
REQ-031 SHALL cover: CLKS_PER_BIT=2 minimum -> every bit lasts exactly 2 cycles; the frame is correct for data=0x00 and data=0xFF.
